// File: rtl/sin_pix_pipe.sv
// Pipelined y = sin(pi*x) evaluator for unsigned fractional x in [0,1):
// quarter-wave fold, sample table, optional linear interpolation, valid/ready on both sides.
module sin_pix_pipe #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int FRAC_W = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic [TAG_W-1:0] out_tag
);

    localparam int AW = IN_W - FRAC_W;
    localparam int N  = 1 << (IN_W - 1 - FRAC_W);
    localparam int FW = (FRAC_W > 0) ? FRAC_W : 1;
    localparam int PW = OUT_W + FW;
    localparam logic [IN_W-1:0] HALF  = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [AW-1:0]   N_IDX = AW'(N);
    localparam logic [PW-1:0]   RND   = PW'((1 << FRAC_W) >> 1);

    // Elaboration-time sine: Taylor series on [0, pi/2], rounded half-up.
    function automatic int sin_entry(input int k);
        real a, term, sum;
        a    = 3.14159265358979323846 * real'(k) / real'(2 * N);
        term = a;
        sum  = a;
        for (int n = 1; n < 12; n++) begin
            term = -term * a * a / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(sum * real'((1 << OUT_W) - 1) + 0.5);
    endfunction

    logic [OUT_W-1:0] tbl [0:N];
    for (genvar k = 0; k <= N; k++) begin : g_tbl
        localparam logic [OUT_W-1:0] TV = OUT_W'(sin_entry(k));
        assign tbl[k] = TV;
    end

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [IN_W-1:0] xf;
    logic [AW-1:0]   i_s;
    logic [FW-1:0]   f_s;
    assign xf  = (in_x > HALF) ? -in_x : in_x;
    assign i_s = AW'(xf >> FRAC_W);
    if (FRAC_W > 0) begin : g_frac
        assign f_s = xf[FW-1:0];
    end else begin : g_nofrac
        assign f_s = '0;
    end

    logic             v1, v2;
    logic [AW-1:0]    i1;
    logic [FW-1:0]    f1, f2;
    logic [TAG_W-1:0] tag1, tag2;
    logic [OUT_W-1:0] t0_q, t1_q;
    logic [AW-1:0]    i1_nx;
    assign i1_nx = (i1 == N_IDX) ? i1 : i1 + AW'(1);

    logic [PW-1:0]    prod;
    logic [OUT_W-1:0] y_c;
    assign prod = PW'(t1_q - t0_q) * PW'(f2) + RND;
    assign y_c  = t0_q + OUT_W'(prod >> FRAC_W);

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_y   <= y_c;
                out_tag <= tag2;
            end
        end
    end

    // NOTE: inner data registers are not reset; their valids gate them, and loading only
    // on a valid keeps undefined idle inputs from ever reaching the table index.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            i1   <= i_s;
            f1   <= f_s;
            tag1 <= in_tag;
        end
        if (adv && v1) begin
            t0_q <= tbl[i1];
            t1_q <= tbl[i1_nx];
            f2   <= f1;
            tag2 <= tag1;
        end
    end

endmodule
